// File: rtl/branch_target_lut.sv
// Branch-target lookup table: N programmable PC targets with per-entry valid bits,
// a registered one-cycle lookup with write bypass, and a sequential table-clear sweep.
module branch_target_lut #(
  parameter int D = 9,
  parameter int A = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init_req,
  output logic         init_busy,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         rd_req,
  input  logic [A-1:0] rd_addr,
  output logic         rd_valid,
  output logic [D-1:0] target,
  output logic         miss
);

  localparam int N = 1 << A;

  typedef enum logic {READY, INIT} state_t;

  state_t         state, state_nxt;
  logic [A-1:0]   sweep, sweep_nxt;
  logic [N-1:0]   valid;
  logic [D-1:0]   mem [N];
  logic           wr_ok;
  logic [D-1:0]   target_p0;
  logic           miss_p0;
  logic           vld_p1;
  logic [D-1:0]   target_p1;
  logic           miss_p1;

  assign wr_ok     = (state == READY) && wr_en;
  assign init_busy = (state == INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= READY;
      sweep <= '0;
    end else begin
      state <= state_nxt;
      sweep <= sweep_nxt;
    end
  end

  // The sweep counter parks at N-1 after a sweep and is re-zeroed on INIT entry.
  always_comb begin
    state_nxt = state;
    sweep_nxt = sweep;
    case (state)
      READY: begin
        if (init_req) begin
          state_nxt = INIT;
          sweep_nxt = '0;
        end
      end
      INIT: begin
        if (sweep == {A{1'b1}}) state_nxt = READY;
        else                    sweep_nxt = sweep + 1'b1;
      end
      default: state_nxt = READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (state == INIT) begin
      valid[sweep] <= 1'b0;
    end else if (wr_ok) begin
      valid[wr_addr] <= 1'b1;
    end
  end

  // Target storage is not reset; stale data stays hidden behind the valid bits.
  always_ff @(posedge clk) begin
    if (state == INIT)  mem[sweep]   <= '0;
    else if (wr_ok)     mem[wr_addr] <= wr_data;
  end

  // Stage p0: combinational lookup with write-through bypass
  always_comb begin
    target_p0 = '0;
    miss_p0   = 1'b1;
    if (state == READY) begin
      if (wr_ok && (wr_addr == rd_addr)) begin
        target_p0 = wr_data;
        miss_p0   = 1'b0;
      end else if (valid[rd_addr]) begin
        target_p0 = mem[rd_addr];
        miss_p0   = 1'b0;
      end
    end
  end

  // Stage p1: registered result, held while no lookup is requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      target_p1 <= '0;
      miss_p1   <= 1'b0;
    end else begin
      vld_p1 <= rd_req;
      if (rd_req) begin
        target_p1 <= target_p0;
        miss_p1   <= miss_p0;
      end
    end
  end

  assign rd_valid = vld_p1;
  assign target   = target_p1;
  assign miss     = miss_p1;

endmodule
